seven_segment_readback: RTL and testbench
=========================================

# seven_segment_readback

Monitor that watches the scanned, multiplexed seven-segment display bus (active-low digit anodes plus active-low cathodes a..g) and reconstructs the hex digit shown on each position. It qualifies each anode slot for stability, decodes the cathode pattern back to a 4-bit nibble, and flags illegal patterns and anode conflicts. A one-cycle pulse is emitted when every digit has been refreshed. It sits beside the display driver so the UART path can read back and self-check what is being displayed.

## Interface
- NUM_DIGITS, 8: number of display positions (anode lines); ≥1.
- SETTLE_CYCLES, 4: consecutive stable cycles required before a capture; ≥1.

- i_Clk  in  1  clock; all logic on the rising edge.
- i_Rst_n  in  1  asynchronous, active-low reset.
- i_Clear  in  1  synchronous clear of captured state.
- i_Anode  in  NUM_DIGITS  digit enables, active-low; bit k = position k.
- i_Segment  in  7  cathodes, active-low; bit 6 = a … bit 0 = g.
- o_Digits  out  4*NUM_DIGITS  decoded nibble of position k in bits [4k+3:4k].
- o_Digit_Invalid  out  NUM_DIGITS  bit k set if the last qualified pattern on position k was not a legal code.
- o_Frame_Valid  out  1  one-cycle pulse when all positions have been captured since the last pulse or clear.
- o_Error  out  1  sticky: more than one anode was low during a qualified window.

## Operation
- Legal codes, abcdefg, 0 = lit: 0 0000001, 1 1001111, 2 0010010, 3 0000110, 4 1001100, 5 0100100, 6 0100000, 7 0001111, 8 0000000, 9 0000100, A 0000010, b 1100000, C 0110001, d 1000010, E 0110000, F 0111000.
- Input stage: {i_Anode, i_Segment} registered into sample s; previous sample s_d kept.
- Stability counter cnt, width $clog2(SETTLE_CYCLES+1): s != s_d → cnt <= 0; else cnt increments, saturating at SETTLE_CYCLES.
- Qualify event: s == s_d and cnt == SETTLE_CYCLES-1. Occurs exactly once per stable window; saturation prevents re-capture.
- On qualify:
  - exactly one anode low (position k) → legal pattern: digit k <= nibble, invalid[k] <= 0; illegal: digit k unchanged, invalid[k] <= 1. Either way seen[k] <= 1.
  - all anodes high (blank) → no action.
  - two or more low → no capture, o_Error <= 1.
- Frame: when the next value of the seen mask would be all ones, o_Frame_Valid = 1 for one cycle and seen is cleared at that edge.
- i_Clear: seen, o_Digit_Invalid, o_Error, o_Frame_Valid <= 0; o_Digits kept; cnt and input stage untouched. If it coincides with a qualify, clear wins and the capture is dropped.

## Timing
- Reset (async assert, sync to clock edge on release): o_Digits 0, o_Digit_Invalid 0, o_Frame_Valid 0, o_Error 0, seen 0, cnt 0, samples 0.
- Latency: inputs held constant from before edge 0 → o_Digits/o_Digit_Invalid update at edge SETTLE_CYCLES+1, i.e. the (SETTLE_CYCLES+2)th edge.
- Any input change restarts qualification; windows shorter than SETTLE_CYCLES+1 cycles produce no capture.
- o_Frame_Valid is asserted on the same edge as the completing capture.
- Reset mid-window discards partial qualification.

## Configuration
- SEVSEG_RB_INPUT_SYNC_EN defined: two-flop synchronizer ahead of the input stage for off-chip sources; latency +2 cycles.
- Not defined: single register input stage as described above.

## Structure
- Shared package seven_segment_pkg: 16-entry legal-code constant array (abcdefg order) and the DIGIT_W = 4 constant, shared with the display driver.
- Sub-module seven_segment_pattern_decoder: combinational 7-bit pattern → {legal, nibble}.

## Test plan
- SETTLE_CYCLES=4. Anode 11111110 and segment 0000110 held 10 cycles → o_Digits[3:0]=3 at edge 5, one capture only.
- Scan positions 0..7 with codes 0..7, 6 cycles each → o_Frame_Valid pulses once after position 7. o_Digits=0x76543210.
- Position 2 with illegal 1111111 → o_Digit_Invalid[2]=1, digit 2 unchanged. Then legal 0110001 → digit 2=C, flag cleared.
- Anode 11111100 held 6 cycles → o_Error=1, no digit change. i_Clear → o_Error=0.
- Glitch: segment changes every 3 cycles → no capture. Then i_Rst_n low mid-window → all outputs 0 immediately.

Source files
------------

// File: rtl/seven_segment_pkg.sv
// seven_segment_pkg: shared seven-segment constants (code table, nibble width).
// No ports; imported by the display driver and the readback monitor.
package seven_segment_pkg;

  localparam int DIGIT_W = 4;

  // abcdefg, bit 6 = a, active-low (0 = lit), index = hex value
  localparam logic [6:0] SEG_CODE [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0000010, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

endpackage

// File: rtl/seven_segment_readback_if.sv
// seven_segment_readback_if: display bus in, readback results out.
// master = display/readback user side, slave = readback monitor.
interface seven_segment_readback_if
  import seven_segment_pkg::*;
#(
  parameter int NUM_DIGITS = 8
);
  logic                          i_Clear;
  logic [NUM_DIGITS-1:0]         i_Anode;
  logic [6:0]                    i_Segment;
  logic [DIGIT_W*NUM_DIGITS-1:0] o_Digits;
  logic [NUM_DIGITS-1:0]         o_Digit_Invalid;
  logic                          o_Frame_Valid;
  logic                          o_Error;

  modport master (
    output i_Clear, i_Anode, i_Segment,
    input  o_Digits, o_Digit_Invalid,
    input  o_Frame_Valid, o_Error
  );

  modport slave (
    input  i_Clear, i_Anode, i_Segment,
    output o_Digits, o_Digit_Invalid,
    output o_Frame_Valid, o_Error
  );
endinterface

// File: rtl/seven_segment_pattern_decoder.sv
// seven_segment_pattern_decoder: 7-bit active-low pattern -> {legal, nibble}.
// Ports: pattern (abcdefg) in; legal, nibble out. Purely combinational.
module seven_segment_pattern_decoder
  import seven_segment_pkg::*;
(
  input  logic [6:0]         pattern,
  output logic               legal,
  output logic [DIGIT_W-1:0] nibble
);

  always_comb begin
    legal  = 1'b0;
    nibble = '0;
    for (int i = 0; i < 16; i++) begin
      if (pattern == SEG_CODE[i]) begin
        legal  = 1'b1;
        nibble = DIGIT_W'(i);
      end
    end
  end

endmodule

// File: rtl/seven_segment_readback.sv
// seven_segment_readback: reconstructs digits from a scanned 7-seg bus.
// Ports: i_Clk, i_Rst_n (async low), bus (slave). Option: SEVSEG_RB_INPUT_SYNC_EN.
module seven_segment_readback
  import seven_segment_pkg::*;
#(
  parameter int NUM_DIGITS    = 8,
  parameter int SETTLE_CYCLES = 4
)(
  input  logic                      i_Clk,
  input  logic                      i_Rst_n,
  seven_segment_readback_if.slave   bus
);

  localparam int W  = NUM_DIGITS + 7;
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(SETTLE_CYCLES);
  localparam logic [CW-1:0] CNT_QUAL = CW'(SETTLE_CYCLES - 1);
  localparam logic [NUM_DIGITS-1:0] ONE = NUM_DIGITS'(1);

  logic [W-1:0] raw, s_in, s, s_d;
  logic [CW-1:0] cnt;

  assign raw = {bus.i_Anode, bus.i_Segment};

`ifdef SEVSEG_RB_INPUT_SYNC_EN
  logic [W-1:0] sync0, sync1;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      sync0 <= '0;
      sync1 <= '0;
    end else begin
      sync0 <= raw;
      sync1 <= sync0;
    end
  end

  assign s_in = sync1;
`else
  assign s_in = raw;
`endif

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      s   <= '0;
      s_d <= '0;
      cnt <= '0;
    end else begin
      s   <= s_in;
      s_d <= s;
      if (s != s_d)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + 1'b1;
    end
  end

  logic               legal;
  logic [DIGIT_W-1:0] nibble;

  seven_segment_pattern_decoder u_dec (
    .pattern (s[6:0]),
    .legal   (legal),
    .nibble  (nibble)
  );

  logic [NUM_DIGITS-1:0] low, seen, seen_nxt;
  logic qual, one_low, multi, frame_hit;

  // cnt saturates past CNT_QUAL, so one stable window qualifies once
  assign qual    = (s == s_d) && (cnt == CNT_QUAL);
  assign low     = ~s[W-1:7];
  assign one_low = (low != '0) && ((low & (low - ONE)) == '0);
  assign multi   = (low != '0) && !one_low;

  assign seen_nxt  = seen | ((qual && one_low) ? low : '0);
  assign frame_hit = &seen_nxt;

  logic [NUM_DIGITS-1:0][DIGIT_W-1:0] digits;
  logic [NUM_DIGITS-1:0]              invalid;
  logic                               frame_valid;
  logic                               error;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      digits      <= '0;
      invalid     <= '0;
      seen        <= '0;
      frame_valid <= 1'b0;
      error       <= 1'b0;
    end else if (bus.i_Clear) begin
      invalid     <= '0;
      seen        <= '0;
      frame_valid <= 1'b0;
      error       <= 1'b0;
    end else begin
      frame_valid <= frame_hit;
      seen        <= frame_hit ? '0 : seen_nxt;
      if (qual && multi)
        error <= 1'b1;
      if (qual && one_low) begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
          if (low[k]) begin
            if (legal)
              digits[k] <= nibble;
            invalid[k] <= !legal;
          end
        end
      end
    end
  end

  assign bus.o_Digits        = digits;
  assign bus.o_Digit_Invalid = invalid;
  assign bus.o_Frame_Valid   = frame_valid;
  assign bus.o_Error         = error;

endmodule

// File: tb/tb_seven_segment_readback.sv
// tb_seven_segment_readback: directed bench for seven_segment_readback.
// NUM_DIGITS=8, SETTLE_CYCLES=4; inputs driven on negedge, sampled on negedge.
module tb_seven_segment_readback;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  int p, ptot;

  always #5 clk = ~clk;

  seven_segment_readback_if #(.NUM_DIGITS(8)) bus ();

  seven_segment_readback #(
    .NUM_DIGITS    (8),
    .SETTLE_CYCLES (4)
  ) dut (
    .i_Clk   (clk),
    .i_Rst_n (rst_n),
    .bus     (bus)
  );

  logic [6:0] code [8] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111
  };

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic [7:0] an, input logic [6:0] sg,
                      input int n, output int pulses);
    pulses = 0;
    bus.i_Anode   = an;
    bus.i_Segment = sg;
    repeat (n) begin
      @(negedge clk);
      if (bus.o_Frame_Valid) pulses++;
    end
  endtask

  initial begin
    bus.i_Clear   = 1'b0;
    bus.i_Anode   = 8'hFF;
    bus.i_Segment = 7'h7F;
    repeat (3) @(negedge clk);
    chk("rst_digits", bus.o_Digits, 32'h0);
    chk("rst_inv", {24'h0, bus.o_Digit_Invalid}, 32'h0);
    chk("rst_fv", {31'h0, bus.o_Frame_Valid}, 32'h0);
    chk("rst_err", {31'h0, bus.o_Error}, 32'h0);
    rst_n = 1'b1;
    hold(8'hFF, 7'h7F, 4, p);

    // single digit: capture lands on edge 5
    hold(8'hFE, 7'b0000110, 5, p);
    ptot = p;
    chk("lat_edge4", {28'h0, bus.o_Digits[3:0]}, 32'h0);
    hold(8'hFE, 7'b0000110, 1, p);
    ptot += p;
    chk("lat_edge5", {28'h0, bus.o_Digits[3:0]}, 32'h3);
    hold(8'hFE, 7'b0000110, 4, p);
    ptot += p;
    chk("hold_digits", bus.o_Digits, 32'h3);
    chk("hold_nofv", ptot, 0);

    // full scan 0..7
    ptot = 0;
    for (int k = 0; k < 7; k++) begin
      hold(~(8'h01 << k), code[k], 6, p);
      ptot += p;
    end
    chk("scan_early_fv", ptot, 0);
    hold(8'h7F, code[7], 6, p);
    chk("scan_last_fv", p, 1);
    chk("scan_digits", bus.o_Digits, 32'h76543210);
    chk("scan_inv", {24'h0, bus.o_Digit_Invalid}, 32'h0);

    // illegal then legal on position 2
    hold(8'hFB, 7'b1111111, 6, p);
    chk("ill_inv", {24'h0, bus.o_Digit_Invalid}, 32'h04);
    chk("ill_digits", bus.o_Digits, 32'h76543210);
    hold(8'hFB, 7'b0110001, 6, p);
    chk("legal_digits", bus.o_Digits, 32'h76543C10);
    chk("legal_inv", {24'h0, bus.o_Digit_Invalid}, 32'h0);

    // anode conflict
    hold(8'hFC, 7'b0000000, 6, p);
    chk("conf_err", {31'h0, bus.o_Error}, 32'h1);
    chk("conf_digits", bus.o_Digits, 32'h76543C10);
    bus.i_Clear = 1'b1;
    @(negedge clk);
    bus.i_Clear = 1'b0;
    chk("clr_err", {31'h0, bus.o_Error}, 32'h0);
    chk("clr_digits", bus.o_Digits, 32'h76543C10);

    // glitchy windows on position 3, then reset mid-window
    hold(8'hF7, 7'b0000000, 3, p);
    hold(8'hF7, 7'b0000100, 3, p);
    hold(8'hF7, 7'b0000000, 3, p);
    hold(8'hF7, 7'b0000100, 2, p);
    chk("glitch_digits", bus.o_Digits, 32'h76543C10);
    chk("glitch_inv", {24'h0, bus.o_Digit_Invalid}, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_digits", bus.o_Digits, 32'h0);
    chk("arst_inv", {24'h0, bus.o_Digit_Invalid}, 32'h0);
    chk("arst_fv", {31'h0, bus.o_Frame_Valid}, 32'h0);
    chk("arst_err", {31'h0, bus.o_Error}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
